micro_sequencer: RTL and testbench

//  Multi-cycle phase sequencer sitting directly downstream of the instruction decoder: consumes
//  the 32-bit MicroInstruct word and steps IF->ID->EXE->MEM->WB, emitting per-cycle strobes
//  (PC/IR/reg/mem writes, PC source) to the datapath. Owns halt and memory wait handshake.

---
 rtl/mseq_pkg.sv | 48 ++++
 rtl/micro_sequencer.sv | 152 +++++++++++++++
 tb/tb_micro_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mseq_pkg.sv
// Shared definitions for the micro_sequencer: phase encodings, micro-instruction
// bit positions, PC source codes and the registered micro-op fields.
package mseq_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam int UI_SRC_IMM   = 1;
  localparam int UI_REG_WRITE = 2;
  localparam int UI_MEM_WRITE = 4;
  localparam int UI_MEM_READ  = 5;
  localparam int UI_JUMP      = 6;
  localparam int UI_BRANCH    = 7;
  localparam int UI_HALT      = 8;
  localparam int UI_MEM       = 30;

  localparam logic [1:0] PCSRC_INC    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Only the micro-instruction fields the sequencer acts on after ID are kept.
  typedef struct packed {
    logic branch;
    logic mem;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic src_imm;
  } uop_t;

  function automatic uop_t decode_uop(input logic [31:0] ui);
    uop_t u;
    u.branch    = ui[UI_BRANCH];
    u.mem       = ui[UI_MEM];
    u.reg_write = ui[UI_REG_WRITE];
    u.mem_read  = ui[UI_MEM_READ];
    u.mem_write = ui[UI_MEM_WRITE];
    u.src_imm   = ui[UI_SRC_IMM];
    return u;
  endfunction

endpackage

// File: rtl/micro_sequencer.sv
// Multi-cycle IF/ID/EXE/MEM/WB phase sequencer with halt and memory-wait handling.
// Optional performance counters (CycleCnt, RetireCnt, CNT_W) exist only with MSEQ_PERF_EN.
module micro_sequencer
  import mseq_pkg::*;
#(
`ifdef MSEQ_PERF_EN
  parameter int CNT_W        = 32,
`endif
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] MicroInstruct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        ALUSrcB,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  State,
`ifdef MSEQ_PERF_EN
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] RetireCnt,
`endif
  output logic        Halted,
  output logic        MemErr
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_t            state;
  uop_t              uop;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout;

  assign mem_timeout = (MEM_WAIT_MAX != 0) && (int'(wait_cnt) == MEM_WAIT_MAX - 1);

  // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch;
  // all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state    <= S_IF;
      uop      <= '0;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      case (state)
        S_IF: state <= S_ID;
        S_ID: begin
          uop <= decode_uop(MicroInstruct);
          if (MicroInstruct[UI_HALT])      state <= S_HALT;
          else if (MicroInstruct[UI_JUMP]) state <= S_IF;
          else if (MicroInstruct == '0)    state <= S_IF;
          else                             state <= S_EXE;
        end
        S_EXE: begin
          wait_cnt <= '0;
          if (uop.branch)         state <= S_IF;
          else if (uop.mem)       state <= S_MEM;
          else if (uop.reg_write) state <= S_WB;
          else                    state <= S_IF;
        end
        S_MEM: begin
          if (MemReady) begin
            state    <= uop.mem_read ? S_WB : S_IF;
            wait_cnt <= '0;
          end else if (mem_timeout) begin
            state  <= S_HALT;
            MemErr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = PCSRC_INC;
    IRWrite  = 1'b0;
    ALUSrcB  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    if (Reset) begin
      case (state)
        S_IF: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = uop.src_imm;
        end
        S_ID: begin
          ALUSrcB = uop.src_imm;
          if (!MicroInstruct[UI_HALT] && MicroInstruct[UI_JUMP]) begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JUMP;
          end
        end
        S_EXE: begin
          ALUSrcB = uop.src_imm;
          if (uop.branch) begin
            PCWrite = Zero;
            PCSrc   = PCSRC_BRANCH;
          end
        end
        S_MEM: begin
          ALUSrcB  = uop.src_imm;
          MemRead  = uop.mem_read;
          MemWrite = uop.mem_write;
        end
        S_WB: begin
          ALUSrcB  = uop.src_imm;
          RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign State  = state;
  assign Halted = (state == S_HALT);

`ifdef MSEQ_PERF_EN
  logic to_if;

  // Instruction completion: any edge that returns the sequencer to IF from a busy phase.
  assign to_if = ((state == S_ID) && !MicroInstruct[UI_HALT] &&
                  (MicroInstruct[UI_JUMP] || (MicroInstruct == '0))) ||
                 ((state == S_EXE) && (uop.branch || (!uop.mem && !uop.reg_write))) ||
                 ((state == S_MEM) && MemReady && !uop.mem_read) ||
                 (state == S_WB);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      CycleCnt  <= '0;
      RetireCnt <= '0;
    end else begin
      if (state != S_HALT) CycleCnt  <= CycleCnt + CNT_W'(1);
      if (to_if)           RetireCnt <= RetireCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed instructions plus random micro-words,
// each expanded into an expected per-cycle phase/strobe trace from the sequencing rules.
module tb_micro_sequencer;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mi;
  logic        zero, mem_ready;
  logic        pc_write, ir_write, alu_src_b, reg_write, mem_read, mem_write;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic        halted, mem_err;
`ifdef MSEQ_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  int passed = 0;
  int total  = 0;
  int model_cycles = 0;
  int model_retired = 0;

  always #5 clk = ~clk;

  micro_sequencer #(.MEM_WAIT_MAX(MAX)) dut (
    .CLK(clk), .Reset(reset), .MicroInstruct(mi), .Zero(zero), .MemReady(mem_ready),
    .PCWrite(pc_write), .PCSrc(pc_src), .IRWrite(ir_write), .ALUSrcB(alu_src_b),
    .RegWrite(reg_write), .MemRead(mem_read), .MemWrite(mem_write), .State(state),
`ifdef MSEQ_PERF_EN
    .CycleCnt(cycle_cnt), .RetireCnt(retire_cnt),
`endif
    .Halted(halted), .MemErr(mem_err)
  );

  // {state, pcw, pcsrc, irw, regw, memrd, memwr}
  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rw;
    logic       mr;
    logic       mw;
  } obs_t;

  typedef struct {
    obs_t o;
    logic ready;
    logic alu_chk;
  } step_t;

  step_t trace[$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  function automatic obs_t observe();
    return '{st: state, pcw: pc_write, pcs: pc_src, irw: ir_write,
             rw: reg_write, mr: mem_read, mw: mem_write};
  endfunction

  function automatic obs_t phase(input int st);
    obs_t o = '0;
    o.st = 3'(st);
    return o;
  endfunction

  task automatic push(input obs_t o, input logic ready, input logic alu_chk);
    step_t s;
    s.o = o; s.ready = ready; s.alu_chk = alu_chk;
    trace.push_back(s);
  endtask

  // Expected trace of one instruction; phases: 0 IF, 1 ID, 2 EXE, 3 MEM, 4 WB, 5 HALT.
  task automatic build(input logic [31:0] ui, input logic z, input int stall);
    obs_t o;
    int   n;
    trace.delete();
    o = phase(0); o.irw = 1; o.pcw = 1;
    push(o, 1'b0, 1'b0);
    o = phase(1);
    if (ui[8]) begin
      push(o, 1'b0, 1'b0); push(phase(5), 1'b0, 1'b0); return;
    end
    if (ui[6]) begin
      o.pcw = 1; o.pcs = 2'b10; push(o, 1'b0, 1'b0); return;
    end
    push(o, 1'b0, 1'b0);
    if (ui == 0) return;
    o = phase(2);
    if (ui[7]) begin
      o.pcw = z; o.pcs = 2'b01; push(o, 1'b0, 1'b1); return;
    end
    push(o, 1'b0, 1'b1);
    if (ui[30]) begin
      n = (stall >= MAX) ? MAX : stall + 1;
      for (int i = 0; i < n; i++) begin
        o = phase(3); o.mr = ui[5]; o.mw = ui[4];
        push(o, (i == stall), 1'b0);
      end
      if (stall >= MAX) begin
        push(phase(5), 1'b0, 1'b0); return;
      end
      if (ui[5]) begin
        o = phase(4); o.rw = 1; push(o, 1'b0, 1'b0);
      end
    end else if (ui[2]) begin
      o = phase(4); o.rw = 1; push(o, 1'b0, 1'b0);
    end
  endtask

  // Called at a negedge while the DUT sits in IF; leaves the bench at the negedge after.
  task automatic run(input string tag, input logic [31:0] ui, input logic z,
                     input int stall, input int abort_at);
    obs_t exp_o;
    build(ui, z, stall);
    mi = ui; zero = z;
    foreach (trace[i]) begin
      mem_ready = (trace[i].o.st == 3'd3) ? trace[i].ready : 1'($urandom);
      exp_o = trace[i].o;
      if (i == abort_at) begin
        reset = 1'b0;
        exp_o = phase(int'(trace[i].o.st));
      end
      #1;
      check($sformatf("%s_c%0d", tag, i), 32'(observe()), 32'(exp_o));
      if (trace[i].alu_chk && i != abort_at) check({tag, "_alusrcb"}, 32'(alu_src_b), 32'(ui[1]));
      if (trace[i].o.st == 3'd5) break;
      model_cycles++;
      @(posedge clk);
      @(negedge clk);
      if (i == abort_at) begin
        reset = 1'b1;
        model_cycles = 0; model_retired = 0;
        #1;
        check({tag, "_abort_state"}, 32'(state), 32'd0);
        return;
      end
    end
    if (trace[trace.size()-1].o.st != 3'd5) model_retired++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    mi = $urandom; mem_ready = 1'b1; zero = 1'b1;
    #1;
    check({tag, "_strobes"}, 32'(observe()) & 32'h7F, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_cycles = 0; model_retired = 0;
    #1;
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_memerr"}, 32'(mem_err), 32'd0);
`ifdef MSEQ_PERF_EN
    check({tag, "_cyc"}, cycle_cnt, 32'd0);
    check({tag, "_ret"}, retire_cnt, 32'd0);
`endif
  endtask

  task automatic check_halt(input string tag, input logic exp_err);
    for (int k = 0; k < 3; k++) begin
      mi = $urandom; mem_ready = 1'($urandom); zero = 1'($urandom);
      #1;
      check($sformatf("%s_hold%0d", tag, k), 32'(observe()), 32'(phase(5)));
      check({tag, "_halted"}, 32'(halted), 32'd1);
      check({tag, "_memerr"}, 32'(mem_err), 32'(exp_err));
      @(negedge clk);
    end
  endtask

  logic [31:0] rui;
  int          rsel;

  initial begin
    reset = 1'b0; mi = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("rst0");

    run("add", 32'hA400_0005, 1'b0, 0, -1);
    run("lw_stall3", 32'hE440_042E, 1'b0, 3, -1);
    run("lw_fast", 32'hE440_042E, 1'b1, 0, -1);
    run("beq_taken", 32'h8C00_0081, 1'b1, 0, -1);
    run("beq_not", 32'h8C00_0081, 1'b0, 0, -1);
    run("jump", 32'h0000_0040, 1'b1, 0, -1);
    run("jump_br", 32'h0000_00C0, 1'b1, 0, -1);
    run("nop", 32'h0000_0000, 1'b0, 0, -1);
    run("sw_fast", 32'h4000_0010, 1'b0, 0, -1);
`ifdef MSEQ_PERF_EN
    #1;
    check("perf_cyc", cycle_cnt, 32'(model_cycles));
    check("perf_ret", retire_cnt, 32'(model_retired));
`endif

    run("sw_timeout", 32'h4000_0010, 1'b0, MAX, -1);
    check_halt("sw_timeout", 1'b1);
    do_reset("rst_err");

    run("halt_jump", 32'h0000_0140, 1'b0, 0, -1);
    check_halt("halt", 1'b0);
    do_reset("rst_halt");

    run("lw_abort", 32'hE440_042E, 1'b0, 2, 4);
`ifdef MSEQ_PERF_EN
    check("abort_cyc", cycle_cnt, 32'd0);
`endif

    for (int n = 0; n < 60; n++) begin
      rsel = int'($urandom_range(0, 5));
      case (rsel)
        0: rui = 32'hA400_0005;
        1: rui = 32'hE440_042E;
        2: rui = 32'h8C00_0081;
        3: rui = 32'h4000_0010;
        4: rui = 32'h0000_0000;
        default: rui = $urandom & ~32'h0000_0100;
      endcase
      run($sformatf("rnd%0d", n), rui, 1'($urandom), int'($urandom_range(0, MAX-1)), -1);
    end
`ifdef MSEQ_PERF_EN
    #1;
    check("rnd_cyc", cycle_cnt, 32'(model_cycles));
    check("rnd_ret", retire_cnt, 32'(model_retired));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
